// File: rtl/mesi_pkg.sv
// Shared coherence definitions: MESI line states, snooping-bus op codes and
// bus controller state encodings.
package mesi_pkg;

  localparam logic [2:0] MESI_INVALID   = 3'b000;
  localparam logic [2:0] MESI_MODIFIED  = 3'b001;
  localparam logic [2:0] MESI_SHARED    = 3'b010;
  localparam logic [2:0] MESI_EXCLUSIVE = 3'b011;

  typedef enum logic [1:0] {
    OP_NONE       = 2'b00,
    OP_READ_MISS  = 2'b01,
    OP_WRITE_MISS = 2'b10,
    OP_INVALIDATE = 2'b11
  } busOp_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_BCAST = 3'b001,
    ST_MEM   = 3'b010,
    ST_WB    = 3'b011,
    ST_DONE  = 3'b100
  } ctrlState_t;

  // Op code 00 is reserved and never counts as a request.
  function automatic logic opValid(input logic [1:0] op);
    return (op != 2'b00);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from lastGrant+1 upward, wrapping modulo
// N_CACHES, and returns the first requester as one-hot plus index.
module rr_arbiter #(
  parameter int N_CACHES = 3
) (
  input  logic [N_CACHES-1:0]         request,
  input  logic [$clog2(N_CACHES)-1:0] lastGrant,
  output logic [N_CACHES-1:0]         winner,
  output logic [$clog2(N_CACHES)-1:0] winnerIdx,
  output logic                        anyValid
);

  localparam int IDX_W = $clog2(N_CACHES);

  logic [IDX_W-1:0] cand;
  logic             hit;

  // Priority search starting just after the previous owner.
  always_comb begin
    winner    = {N_CACHES{1'b0}};
    winnerIdx = {IDX_W{1'b0}};
    anyValid  = 1'b0;
    cand      = {IDX_W{1'b0}};
    hit       = 1'b0;
    for (int off = 1; off <= N_CACHES; off++) begin
      cand         = IDX_W'((int'(lastGrant) + off) % N_CACHES);
      hit          = !anyValid && request[cand];
      winner[cand] = winner[cand] | hit;
      winnerIdx    = hit ? cand : winnerIdx;
      anyValid     = anyValid | hit;
    end
  end

endmodule

// File: rtl/snoop_bus_controller.sv
// Snooping-bus controller: arbitrates cache requests, broadcasts one coherence
// op per tenure, then runs a memory read, owner write-back or nothing.
module snoop_bus_controller
  import mesi_pkg::*;
#(
  parameter int N_CACHES = 3,
  parameter int ADDR_W   = 5,
  parameter int MEM_LAT  = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_CACHES-1:0]          req,
  input  logic [2*N_CACHES-1:0]        req_op,
  input  logic [ADDR_W*N_CACHES-1:0]   req_addr,
  input  logic [N_CACHES-1:0]          snoop_abort,
  output logic [N_CACHES-1:0]          grant,
  output logic                         bus_readMiss,
  output logic                         bus_writeMiss,
  output logic                         bus_invalidate,
  output logic [ADDR_W-1:0]            bus_addr,
  output logic [$clog2(N_CACHES)-1:0]  bus_src,
  output logic                         mem_read,
  output logic                         mem_wb,
  output logic [N_CACHES-1:0]          done,
  output logic                         shared
);

  localparam int SRC_W = $clog2(N_CACHES);
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [N_CACHES-1:0] ONE_HOT = {{(N_CACHES-1){1'b0}}, 1'b1};

  ctrlState_t          state_r, nextState;
  busOp_t              op_r, nextOp, selOp;
  logic [ADDR_W-1:0]   addr_r, nextAddr, selAddr;
  logic [SRC_W-1:0]    src_r, nextSrc, lastGrant_r, nextLastGrant;
  logic                abort_r, nextAbort, maskedAbort;
  logic [CNT_W-1:0]    cnt_r, nextCnt;
  logic [N_CACHES-1:0] reqValid, winner;
  logic [SRC_W-1:0]    winIdx;
  logic                anyValid;

  logic [N_CACHES-1:0] grantNext, doneNext;
  logic                readMissNext, writeMissNext, invalidateNext;
  logic [ADDR_W-1:0]   busAddrNext;
  logic [SRC_W-1:0]    busSrcNext;
  logic                memReadNext, memWbNext, sharedNext;

  // Qualify requests and pick out the winner's op and address.
  always_comb begin
    reqValid = {N_CACHES{1'b0}};
    selOp    = OP_NONE;
    selAddr  = {ADDR_W{1'b0}};
    for (int i = 0; i < N_CACHES; i++) begin
      reqValid[i] = req[i] && opValid(req_op[2*i +: 2]);
      selOp       = (int'(winIdx) == i) ? busOp_t'(req_op[2*i +: 2]) : selOp;
      selAddr     = (int'(winIdx) == i) ? req_addr[ADDR_W*i +: ADDR_W] : selAddr;
    end
  end

  assign maskedAbort = |(snoop_abort & ~(ONE_HOT << src_r));

  rr_arbiter #(.N_CACHES(N_CACHES)) arb (
    .request   (reqValid),
    .lastGrant (lastGrant_r),
    .winner    (winner),
    .winnerIdx (winIdx),
    .anyValid  (anyValid)
  );

  // Next-state and tenure bookkeeping.
  always_comb begin
    nextState     = state_r;
    nextOp        = op_r;
    nextAddr      = addr_r;
    nextSrc       = src_r;
    nextAbort     = abort_r;
    nextCnt       = cnt_r;
    nextLastGrant = lastGrant_r;
    case (state_r)
      ST_IDLE: begin
        if (anyValid) begin
          nextState = ST_BCAST;
          nextOp    = selOp;
          nextAddr  = selAddr;
          nextSrc   = winIdx;
          nextAbort = 1'b0;
        end else begin
          nextState = ST_IDLE;
        end
      end
      ST_BCAST: begin
        nextAbort = maskedAbort;
        if (op_r == OP_INVALIDATE) begin
          nextState = ST_DONE;
        end else if (maskedAbort) begin
          nextState = ST_WB;
        end else begin
          nextState = ST_MEM;
          nextCnt   = CNT_W'(MEM_LAT - 1);
        end
      end
      ST_MEM: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          nextState = ST_DONE;
        end else begin
          nextCnt = cnt_r - CNT_W'(1);
        end
      end
      ST_WB:   nextState = ST_DONE;
      ST_DONE: begin
        nextLastGrant = src_r;
        nextState     = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // Outputs are registered, so derive them from the state being entered.
  always_comb begin
    grantNext      = {N_CACHES{1'b0}};
    doneNext       = {N_CACHES{1'b0}};
    readMissNext   = 1'b0;
    writeMissNext  = 1'b0;
    invalidateNext = 1'b0;
    busAddrNext    = {ADDR_W{1'b0}};
    busSrcNext     = {SRC_W{1'b0}};
    memReadNext    = (nextState == ST_MEM);
    memWbNext      = (nextState == ST_WB);
    sharedNext     = 1'b0;
    if (nextState != ST_IDLE) begin
      grantNext   = ONE_HOT << nextSrc;
      busAddrNext = nextAddr;
      busSrcNext  = nextSrc;
    end else begin
      grantNext = {N_CACHES{1'b0}};
    end
    if (nextState == ST_BCAST) begin
      readMissNext   = (nextOp == OP_READ_MISS);
      writeMissNext  = (nextOp == OP_WRITE_MISS);
      invalidateNext = (nextOp == OP_INVALIDATE);
    end else begin
      readMissNext = 1'b0;
    end
    if (nextState == ST_DONE) begin
      doneNext   = ONE_HOT << nextSrc;
      sharedNext = nextAbort;
    end else begin
      doneNext = {N_CACHES{1'b0}};
    end
  end

  // State, tenure registers and registered outputs; reset abandons any tenure.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      op_r           <= OP_NONE;
      addr_r         <= {ADDR_W{1'b0}};
      src_r          <= {SRC_W{1'b0}};
      abort_r        <= 1'b0;
      cnt_r          <= {CNT_W{1'b0}};
      lastGrant_r    <= SRC_W'(N_CACHES - 1);
      grant          <= {N_CACHES{1'b0}};
      bus_readMiss   <= 1'b0;
      bus_writeMiss  <= 1'b0;
      bus_invalidate <= 1'b0;
      bus_addr       <= {ADDR_W{1'b0}};
      bus_src        <= {SRC_W{1'b0}};
      mem_read       <= 1'b0;
      mem_wb         <= 1'b0;
      done           <= {N_CACHES{1'b0}};
      shared         <= 1'b0;
    end else begin
      state_r        <= nextState;
      op_r           <= nextOp;
      addr_r         <= nextAddr;
      src_r          <= nextSrc;
      abort_r        <= nextAbort;
      cnt_r          <= nextCnt;
      lastGrant_r    <= nextLastGrant;
      grant          <= grantNext;
      bus_readMiss   <= readMissNext;
      bus_writeMiss  <= writeMissNext;
      bus_invalidate <= invalidateNext;
      bus_addr       <= busAddrNext;
      bus_src        <= busSrcNext;
      mem_read       <= memReadNext;
      mem_wb         <= memWbNext;
      done           <= doneNext;
      shared         <= sharedNext;
    end
  end

endmodule
